pcr_fraction_collector: RTL and testbench

Sequential controller at the output end of the PCR mixing chain: it consumes the product stream leaving the final serpentine and steers it through a waste valve and N collection-well valves. A flow sensor on the chip output provides one pulse per unit volume plus an air-bubble flag. The controller first primes the dead volume to waste, then fills each well in turn with a fixed volume. Every switch is break-before-make, and it stops safely on a bubble or an abort.

---
 rtl/pcr_collect_pkg.sv | 24 ++
 rtl/pcr_fraction_collector_counter.sv | 37 +++
 rtl/pcr_fraction_collector.sv | 180 ++++++++++++++++++
 tb/tb_pcr_fraction_collector.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pcr_collect_pkg.sv
// Shared types and defaults for the PCR output fraction collector.
package pcr_collect_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRIME,
    ST_SWITCH,
    ST_FILL,
    ST_DONE,
    ST_ERROR
  } collect_state_e;

  localparam int DEF_N_WELLS     = 4;
  localparam int DEF_TICK_W      = 16;
  localparam int DEF_PRIME_TICKS = 8;
  localparam int DEF_FILL_TICKS  = 32;
  localparam int DEF_SETTLE_CYC  = 4;

  // Index width that stays at least one bit for single-entry ranges.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pcr_fraction_collector_counter.sv
// Volume tick counter with synchronous clear and a terminal flag raised on the
// increment that brings the count up to the limit.
module collect_tick_counter #(
  parameter int TICK_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              inc,
  input  logic [TICK_W-1:0] limit,
  output logic [TICK_W-1:0] count,
  output logic              term
);

  logic [TICK_W-1:0] count_d, count_q;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = count_q + TICK_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign term  = inc && ((count_q + TICK_W'(1)) == limit);

endmodule

// File: rtl/pcr_fraction_collector.sv
// Output-end fraction collector: primes dead volume to waste, then fills each
// well with a fixed volume, with break-before-make settling between routings.
//
// state  | meaning
// IDLE   | all valves closed, waiting for start
// PRIME  | waste open, counting dead-volume ticks
// SWITCH | all valves closed for the settle time, ticks counted as dropped
// FILL   | current well open, counting delivered ticks
// DONE   | every well filled, valves closed
// ERROR  | bubble seen while filling, valves closed until abort
module pcr_fraction_collector
  import pcr_collect_pkg::*;
#(
  parameter int N_WELLS     = DEF_N_WELLS,
  parameter int TICK_W      = DEF_TICK_W,
  parameter int PRIME_TICKS = DEF_PRIME_TICKS,
  parameter int FILL_TICKS  = DEF_FILL_TICKS,
  parameter int SETTLE_CYC  = DEF_SETTLE_CYC
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  input  logic                             flow_tick,
  input  logic                             bubble,
  output logic                             waste_valve,
  output logic [N_WELLS-1:0]               well_valve,
  output logic [idx_width(N_WELLS)-1:0]    well_idx,
  output logic [TICK_W-1:0]                fill_count,
  output logic [7:0]                       drop_count,
  output logic                             busy,
  output logic                             done,
  output logic                             error
);

  localparam int IDX_W = idx_width(N_WELLS);
  localparam int SET_W = idx_width(SETTLE_CYC);
  localparam logic [IDX_W-1:0] LAST_IDX    = IDX_W'(N_WELLS - 1);
  localparam logic [SET_W-1:0] SETTLE_LOAD = SET_W'(SETTLE_CYC - 1);

  collect_state_e     state_d, state_q;
  logic [IDX_W-1:0]   well_idx_d, well_idx_q;
  logic [SET_W-1:0]   settle_d, settle_q;
  logic [7:0]         drop_d, drop_q;
  logic               waste_valve_d, waste_valve_q;
  logic [N_WELLS-1:0] well_valve_d, well_valve_q;
  logic               busy_d, busy_q;
  logic               done_d, done_q;
  logic               error_d, error_q;

  logic               prime_clr, prime_inc, prime_term;
  logic               fill_clr, fill_inc, fill_term;
  logic [TICK_W-1:0]  prime_cnt_unused;
  logic [TICK_W-1:0]  fill_cnt;

  // Abort and bubble both suppress counting so held values reflect delivered volume.
  assign prime_inc = !abort && (state_q == ST_PRIME) && flow_tick;
  assign fill_inc  = !abort && (state_q == ST_FILL) && flow_tick && !bubble;

  collect_tick_counter #(.TICK_W(TICK_W)) u_prime_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (prime_clr),
    .inc   (prime_inc),
    .limit (TICK_W'(PRIME_TICKS)),
    .count (prime_cnt_unused),
    .term  (prime_term)
  );

  collect_tick_counter #(.TICK_W(TICK_W)) u_fill_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (fill_clr),
    .inc   (fill_inc),
    .limit (TICK_W'(FILL_TICKS)),
    .count (fill_cnt),
    .term  (fill_term)
  );

  always_comb begin
    state_d    = state_q;
    well_idx_d = well_idx_q;
    settle_d   = settle_q;
    drop_d     = drop_q;
    prime_clr  = 1'b0;
    fill_clr   = 1'b0;

    if (abort) begin
      state_d = ST_IDLE;
    end else begin
      unique case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_d    = ST_PRIME;
            well_idx_d = '0;
            drop_d     = '0;
            prime_clr  = 1'b1;
            fill_clr   = 1'b1;
          end
        end
        ST_PRIME: begin
          if (prime_term) begin
            state_d    = ST_SWITCH;
            settle_d   = SETTLE_LOAD;
            well_idx_d = '0;
          end
        end
        ST_SWITCH: begin
          if (flow_tick && (drop_q != 8'hFF)) begin
            drop_d = drop_q + 8'd1;
          end
          if (settle_q == '0) begin
            state_d  = ST_FILL;
            fill_clr = 1'b1;
          end else begin
            settle_d = settle_q - SET_W'(1);
          end
        end
        ST_FILL: begin
          if (bubble) begin
            state_d = ST_ERROR;
          end else if (fill_term) begin
            if (well_idx_q == LAST_IDX) begin
              state_d = ST_DONE;
            end else begin
              state_d    = ST_SWITCH;
              settle_d   = SETTLE_LOAD;
              well_idx_d = well_idx_q + IDX_W'(1);
            end
          end
        end
        ST_ERROR: state_d = ST_ERROR;
        default:  state_d = ST_IDLE;
      endcase
    end

    // Valve pattern is decoded from the next state so it moves on the same edge.
    waste_valve_d = (state_d == ST_PRIME);
    for (int i = 0; i < N_WELLS; i++) begin
      well_valve_d[i] = (state_d == ST_FILL) && (well_idx_d == IDX_W'(i));
    end
    busy_d  = (state_d == ST_PRIME) || (state_d == ST_SWITCH) || (state_d == ST_FILL);
    done_d  = (state_d == ST_DONE);
    error_d = (state_d == ST_ERROR);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      well_idx_q    <= '0;
      settle_q      <= '0;
      drop_q        <= '0;
      waste_valve_q <= 1'b0;
      well_valve_q  <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      well_idx_q    <= well_idx_d;
      settle_q      <= settle_d;
      drop_q        <= drop_d;
      waste_valve_q <= waste_valve_d;
      well_valve_q  <= well_valve_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      error_q       <= error_d;
    end
  end

  assign waste_valve = waste_valve_q;
  assign well_valve  = well_valve_q;
  assign well_idx    = well_idx_q;
  assign fill_count  = fill_cnt;
  assign drop_count  = drop_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign error       = error_q;

endmodule

// File: tb/tb_pcr_fraction_collector.sv
// Scoreboarded bench: each run pushes its expected valve routings, a negedge
// monitor pops and compares them as the valves close.
module tb_pcr_fraction_collector;

  localparam int N_WELLS = 4;
  localparam int TICK_W  = 16;
  localparam int PRIME   = 3;
  localparam int FILL    = 5;
  localparam int SETTLE  = 2;
  localparam int R_NONE  = -1;
  localparam int R_WASTE = 100;

  logic                clk, rst_n, start, abort, flow_tick, bubble;
  logic                waste_valve;
  logic [N_WELLS-1:0]  well_valve;
  logic [1:0]          well_idx;
  logic [TICK_W-1:0]   fill_count;
  logic [7:0]          drop_count;
  logic                busy, done, error;

  pcr_fraction_collector #(
    .N_WELLS(N_WELLS), .TICK_W(TICK_W), .PRIME_TICKS(PRIME),
    .FILL_TICKS(FILL), .SETTLE_CYC(SETTLE)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .flow_tick(flow_tick), .bubble(bubble), .waste_valve(waste_valve),
    .well_valve(well_valve), .well_idx(well_idx), .fill_count(fill_count),
    .drop_count(drop_count), .busy(busy), .done(done), .error(error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int route;
    int ticks;
    int fill;
  } seg_t;

  seg_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic expect_seg(input int route, input int ticks, input int fill);
    seg_t s;
    s.route = route;
    s.ticks = ticks;
    s.fill  = fill;
    sb_q.push_back(s);
  endtask

  function automatic int route_of(input logic w, input logic [N_WELLS-1:0] v);
    if (w) return R_WASTE;
    for (int i = 0; i < N_WELLS; i++) if (v[i]) return i;
    return R_NONE;
  endfunction

  // Monitor: tracks open segments, ticks delivered and closed-gap length.
  int   cur_route = R_NONE;
  int   seg_ticks = 0;
  int   gap_cyc   = 0;
  int   mon_r;
  seg_t mon_e;

  always @(negedge clk) begin
    mon_r = route_of(waste_valve, well_valve);
    check_val("valve_overlap", int'(waste_valve && (well_valve != '0)), 0);
    check_val("well_onehot", int'($countones(well_valve) <= 1), 1);
    if (mon_r != cur_route) begin
      if (cur_route != R_NONE) begin
        if (sb_q.size() == 0) begin
          check_val("unexpected_route", cur_route, R_NONE);
        end else begin
          mon_e = sb_q.pop_front();
          check_val("seg_route", cur_route, mon_e.route);
          check_val("seg_ticks", seg_ticks, mon_e.ticks);
          if (mon_e.fill >= 0) check_val("seg_fill_at_close", int'(fill_count), mon_e.fill);
        end
      end
      if (mon_r != R_NONE && mon_r != R_WASTE) check_val("settle_gap", gap_cyc, SETTLE);
      if (mon_r == R_NONE) gap_cyc = 0;
      cur_route = mon_r;
      seg_ticks = 0;
    end
    if (mon_r == R_NONE) gap_cyc++;
    else if (flow_tick && (mon_r == R_WASTE || !bubble)) seg_ticks++;
  end

  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic pulse_abort();
    abort = 1'b1;
    cyc();
    abort = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check_val({tag, "_waste"}, int'(waste_valve), 0);
    check_val({tag, "_wells"}, int'(well_valve), 0);
    check_val({tag, "_busy"}, int'(busy), 0);
    check_val({tag, "_done"}, int'(done), 0);
    check_val({tag, "_error"}, int'(error), 0);
  endtask

  // Runs with continuous flow until the given well has been open for n_hit
  // cycles, then raises bubble for that cycle. Returns when error is seen.
  task automatic run_bubble(input int well, input int n_hit);
    int n, c;
    n = 0;
    c = 0;
    while (!error && c < 200) begin
      cyc();
      c++;
      if (well_valve == N_WELLS'(1 << well)) begin
        n++;
        if (n == n_hit) bubble = 1'b1;
      end
    end
    bubble = 1'b0;
    check_val("bubble_error_timeout", int'(error), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c, n;
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; flow_tick = 1'b0; bubble = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check_idle_outputs("reset");
    check_val("reset_idx", int'(well_idx), 0);
    check_val("reset_fill", int'(fill_count), 0);
    check_val("reset_drop", int'(drop_count), 0);
    rst_n = 1'b1;
    cyc();

    // Nominal run with a tick every cycle, including through SWITCH.
    expect_seg(R_WASTE, PRIME, -1);
    for (int w = 0; w < N_WELLS; w++) expect_seg(w, FILL, FILL);
    flow_tick = 1'b1;
    pulse_start();
    check_val("start_waste_latency", int'(waste_valve), 1);
    check_val("start_busy", int'(busy), 1);
    c = 0;
    while (!done && c < 100) begin cyc(); c++; end
    check_val("nominal_done_timeout", int'(done), 1);
    cyc();
    check_val("nominal_done", int'(done), 1);
    check_val("nominal_busy", int'(busy), 0);
    check_val("nominal_idx", int'(well_idx), 3);
    check_val("nominal_fill", int'(fill_count), FILL);
    check_val("nominal_drop", int'(drop_count), 2 * SETTLE * N_WELLS / 2);
    check_val("nominal_sb_empty", sb_q.size(), 0);

    // Restart from DONE, bubble on the third tick of well 1.
    expect_seg(R_WASTE, PRIME, -1);
    expect_seg(0, FILL, FILL);
    expect_seg(1, 2, 2);
    pulse_start();
    check_val("restart_fill_clr", int'(fill_count), 0);
    check_val("restart_drop_clr", int'(drop_count), 0);
    check_val("restart_idx_clr", int'(well_idx), 0);
    run_bubble(1, 3);
    check_val("bubble_error", int'(error), 1);
    check_val("bubble_wells", int'(well_valve), 0);
    check_val("bubble_waste", int'(waste_valve), 0);
    check_val("bubble_idx", int'(well_idx), 1);
    check_val("bubble_fill", int'(fill_count), 2);
    check_val("bubble_busy", int'(busy), 0);
    pulse_start();
    repeat (3) cyc();
    check_val("error_ignores_start", int'(error), 1);
    check_val("error_start_busy", int'(busy), 0);
    pulse_abort();
    check_idle_outputs("abort_from_error");
    check_val("abort_hold_idx", int'(well_idx), 1);
    check_val("abort_hold_fill", int'(fill_count), 2);
    check_val("abort_hold_drop", int'(drop_count), 4);
    check_val("bubble_sb_empty", sb_q.size(), 0);

    // Abort mid-PRIME after one tick, then a clean restart.
    flow_tick = 1'b0;
    expect_seg(R_WASTE, 1, -1);
    pulse_start();
    check_val("idle_start_fill_clr", int'(fill_count), 0);
    check_val("idle_start_idx_clr", int'(well_idx), 0);
    check_val("idle_start_drop_clr", int'(drop_count), 0);
    flow_tick = 1'b1;
    cyc();
    flow_tick = 1'b0;
    pulse_abort();
    check_idle_outputs("abort_prime");
    cyc();
    check_val("abort_prime_sb_empty", sb_q.size(), 0);

    // Restart and hit async reset while well 1 is filling.
    expect_seg(R_WASTE, PRIME, -1);
    expect_seg(0, FILL, FILL);
    expect_seg(1, 2, 0);
    flow_tick = 1'b1;
    pulse_start();
    check_val("restart2_waste", int'(waste_valve), 1);
    n = 0;
    c = 0;
    while (n < 3 && c < 200) begin
      cyc();
      c++;
      if (well_valve == 4'b0010) n++;
    end
    check_val("reset_midfill_reached", n, 3);
    #1 rst_n = 1'b0;
    #1;
    check_idle_outputs("async_reset");
    check_val("async_reset_idx", int'(well_idx), 0);
    check_val("async_reset_fill", int'(fill_count), 0);
    check_val("async_reset_drop", int'(drop_count), 0);
    cyc();
    rst_n = 1'b1;
    cyc();
    check_val("reset_sb_empty", sb_q.size(), 0);

    // Terminal tick on well 2 coinciding with bubble: tick is dropped.
    expect_seg(R_WASTE, PRIME, -1);
    expect_seg(0, FILL, FILL);
    expect_seg(1, FILL, FILL);
    expect_seg(2, FILL - 1, FILL - 1);
    pulse_start();
    run_bubble(2, FILL);
    repeat (20) cyc();
    check_val("term_bubble_error", int'(error), 1);
    check_val("term_bubble_idx", int'(well_idx), 2);
    check_val("term_bubble_fill", int'(fill_count), FILL - 1);
    check_val("term_bubble_wells", int'(well_valve), 0);
    check_val("term_bubble_sb_empty", sb_q.size(), 0);
    flow_tick = 1'b0;
    pulse_abort();
    check_idle_outputs("final_abort");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
